// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of the requester-side and consumer-side signals of the 8:1 round-robin
// arbiter. The arbiter connects through the slave modport; the sources and the
// consumer (or a testbench standing in for them) use the master modport.
interface mux8_rr_arbiter_if #(
   parameter int WIDTH = 64
);

   logic [7:0]         Req;
   logic [8*WIDTH-1:0] DataIn;
   logic [7:0]         Ack;
   logic [7:0]         Grant;
   logic [2:0]         Sel;
   logic               Busy;
   logic [WIDTH-1:0]   OutData;
   logic               OutValid;
   logic               OutReady;

   modport slave (
      input  Req,
      input  DataIn,
      input  OutReady,
      output Ack,
      output Grant,
      output Sel,
      output Busy,
      output OutData,
      output OutValid
   );

   modport master (
      output Req,
      output DataIn,
      output OutReady,
      input  Ack,
      input  Grant,
      input  Sel,
      input  Busy,
      input  OutData,
      input  OutValid
   );

endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one 8:1 x WIDTH selection
// datapath among eight requesters. An owner keeps the grant for up to
// MAX_BURST beats or until it drops its request, then the search pointer moves
// one past it. Beats land in a registered valid/ready output stage.
module mux8_rr_arbiter #(
   parameter int WIDTH     = 64,
   parameter int MAX_BURST = 4
) (
   input logic              clk,
   input logic              rst,
   mux8_rr_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE,
      OWN
   } state_t;

   localparam logic [4:0] LAST_CNT = 5'(MAX_BURST - 1);

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       sel_q, sel_d;
   logic [7:0]       grant_q, grant_d;
   logic [4:0]       beat_cnt_q, beat_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   logic [7:0]       ack;
   logic [2:0]       scan_idx;
   logic [2:0]       win_idx;
   logic             found;
   logic             space;
   logic             owner_req;
   logic             owner_ack;
   logic             last_beat;
   logic [WIDTH-1:0] owner_data;

   assign space      = !out_valid_q || bus.OutReady;
   assign owner_req  = bus.Req[sel_q];
   assign owner_ack  = (state_q == OWN) && owner_req && space;
   assign owner_data = bus.DataIn[WIDTH*sel_q +: WIDTH];
   assign last_beat  = owner_ack && (beat_cnt_q == LAST_CNT);

   // Find the first requester at or after the rotating pointer, wrapping mod 8.
   always_comb begin
      found    = 1'b0;
      win_idx  = ptr_q;
      scan_idx = ptr_q;
      for (int i = 0; i < 8; i++) begin
         scan_idx = ptr_q + 3'(i);
         if (!found && bus.Req[scan_idx]) begin
            found   = 1'b1;
            win_idx = scan_idx;
         end
      end
   end

   // Next-state logic: grant in IDLE, move beats and decide release in OWN.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ack         = '0;

      case (state_q)
         IDLE: begin
            if (out_valid_q && bus.OutReady) begin
               out_valid_d = 1'b0;
            end
            if (found) begin
               state_d    = OWN;
               grant_d    = 8'b1 << win_idx;
               sel_d      = win_idx;
               beat_cnt_d = '0;
            end
         end

         OWN: begin
            if (owner_ack) begin
               ack         = 8'b1 << sel_q;
               out_data_d  = owner_data;
               out_valid_d = 1'b1;
               beat_cnt_d  = beat_cnt_q + 5'd1;
            end else if (out_valid_q && bus.OutReady) begin
               out_valid_d = 1'b0;
            end
            if (!owner_req || last_beat) begin
               state_d    = IDLE;
               grant_d    = '0;
               ptr_d      = sel_q + 3'd1;
               beat_cnt_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything including a pending beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         grant_q     <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.Ack      = ack;
   assign bus.Grant    = grant_q;
   assign bus.Sel      = sel_q;
   assign bus.Busy     = (state_q == OWN);
   assign bus.OutData  = out_data_q;
   assign bus.OutValid = out_valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: a hand-derived vector table for a
// single requester, directed multi-cycle corner cases, and a randomized run
// compared against a transaction-level round-robin model.
module tb_mux8_rr_arbiter;

   localparam int W         = 64;
   localparam int MAX_BURST = 4;

   typedef struct {
      logic [7:0]   req;
      logic         ready;
      logic [7:0]   ack;
      logic [7:0]   grant;
      logic [2:0]   sel;
      logic         busy;
      logic         valid;
      logic [W-1:0] data;
   } vec_t;

   logic clk;
   logic rst;

   mux8_rr_arbiter_if #(.WIDTH(W)) bus ();

   mux8_rr_arbiter #(
      .WIDTH     (W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   int           m_owner;
   int           m_ptr;
   int           m_beats;
   int           m_sel;
   logic         m_valid;
   logic [W-1:0] m_data;

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8*W-1:0] randData();
      logic [8*W-1:0] d;
      for (int i = 0; i < 8; i++) begin
         d[W*i +: W] = {$urandom, $urandom};
      end
      return d;
   endfunction

   function automatic int onehotIdx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_sel   = 0;
      m_valid = 1'b0;
      m_data  = '0;
   endtask

   function automatic logic [7:0] modelAck(input logic [7:0] req, input logic ready);
      if (m_owner >= 0 && req[m_owner] && (!m_valid || ready)) return 8'(1 << m_owner);
      return 8'h00;
   endfunction

   // Advance the model over one rising edge given the inputs seen just before it.
   task automatic modelEdge(input logic [7:0] req, input logic [8*W-1:0] data,
                            input logic ready, input logic in_rst);
      logic [7:0] a;
      bit         taken;
      int         g;
      a = modelAck(req, ready);
      if (in_rst) begin
         modelReset();
         return;
      end
      if (m_owner < 0) begin
         if (m_valid && ready) m_valid = 1'b0;
         taken = 1'b0;
         for (int k = 0; k < 8; k++) begin
            g = (m_ptr + k) % 8;
            if (!taken && req[g]) begin
               taken   = 1'b1;
               m_owner = g;
               m_sel   = g;
               m_beats = 0;
            end
         end
      end else begin
         if (a != 8'h00) begin
            m_data  = data[W*m_owner +: W];
            m_valid = 1'b1;
            m_beats = m_beats + 1;
         end else if (m_valid && ready) begin
            m_valid = 1'b0;
         end
         if (!req[m_owner] || m_beats == MAX_BURST) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_beats = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] req, input logic [8*W-1:0] data,
                                input logic ready);
      bus.Req      = req;
      bus.DataIn   = data;
      bus.OutReady = ready;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] e_ack,
                              input logic [7:0] e_grant, input logic [2:0] e_sel,
                              input logic e_busy, input logic e_valid,
                              input logic [W-1:0] e_data);
      tests_run++;
      if (bus.Ack !== e_ack || bus.Grant !== e_grant || bus.Sel !== e_sel ||
          bus.Busy !== e_busy || bus.OutValid !== e_valid || bus.OutData !== e_data) begin
         tests_failed++;
         $display("[TB] FAIL %s @%0t: got ack=%h grant=%h sel=%0d busy=%b valid=%b data=%h, want ack=%h grant=%h sel=%0d busy=%b valid=%b data=%h",
                  name, $time, bus.Ack, bus.Grant, bus.Sel, bus.Busy, bus.OutValid, bus.OutData,
                  e_ack, e_grant, e_sel, e_busy, e_valid, e_data);
      end
   endtask

   task automatic checkInt(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, actual, expected);
      end
   endtask

   task automatic checkModel(input string name);
      logic [7:0] e_grant;
      e_grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      checkOutput(name, modelAck(bus.Req, bus.OutReady), e_grant, 3'(m_sel),
                  m_owner >= 0, m_valid, m_data);
   endtask

   task automatic stepEdge();
      modelEdge(bus.Req, bus.DataIn, bus.OutReady, rst);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      bus.Req = 8'h00;
      rst     = 1'b1;
      #1;
      modelReset();
      stepEdge();
      rst = 1'b0;
   endtask

   // Directed sequences, vector table and randomized run.
   initial begin
      vec_t           vecs[7];
      logic [8*W-1:0] tbl_data;
      logic [8*W-1:0] d;
      logic [W-1:0]   held;
      logic [7:0]     prev_grant;
      logic [7:0]     rnd_req;
      int             starts[$];
      int             beats[8];
      int             ack_cnt;

      for (int i = 0; i < 8; i++) begin
         tbl_data[W*i +: W] = {8{8'(8'h11 * (i + 1))}};
      end
      tbl_data[W*2 +: W] = 64'hA5A5_A5A5_A5A5_A5A5;

      vecs[0] = '{8'h04, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 64'h0};
      vecs[1] = '{8'h04, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0, 64'h0};
      vecs[2] = '{8'h04, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
      vecs[3] = '{8'h04, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
      vecs[4] = '{8'h04, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
      vecs[5] = '{8'h04, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
      vecs[6] = '{8'h04, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};

      rst          = 1'b1;
      bus.Req      = 8'($urandom);
      bus.DataIn   = randData();
      bus.OutReady = 1'b1;
      modelReset();
      #2;
      checkOutput("reset_async", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, '0);
      stepEdge();
      checkOutput("reset_held", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, '0);
      rst = 1'b0;
      applyStimulus(8'h00, randData(), 1'b1);
      checkModel("idle_after_reset");
      stepEdge();
      applyStimulus(8'h00, randData(), 1'b1);
      checkOutput("idle_stays", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, '0);
      stepEdge();

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].req, tbl_data, vecs[i].ready);
         checkOutput($sformatf("single_vec%0d", i), vecs[i].ack, vecs[i].grant,
                     vecs[i].sel, vecs[i].busy, vecs[i].valid, vecs[i].data);
         stepEdge();
      end

      doReset();
      prev_grant = 8'h00;
      for (int i = 0; i < 8; i++) beats[i] = 0;
      for (int c = 0; c < 42; c++) begin
         applyStimulus(8'hFF, randData(), 1'b1);
         checkModel("contention");
         if (bus.Grant != 8'h00 && prev_grant == 8'h00) starts.push_back(onehotIdx(bus.Grant));
         if (c <= 40) begin
            for (int i = 0; i < 8; i++) if (bus.Ack[i]) beats[i]++;
         end
         prev_grant = bus.Grant;
         stepEdge();
      end
      checkInt("contention_grant_count", starts.size(), 9);
      foreach (starts[k]) checkInt($sformatf("contention_order%0d", k), starts[k], k % 8);
      for (int i = 0; i < 8; i++) checkInt($sformatf("contention_beats%0d", i), beats[i], MAX_BURST);

      doReset();
      ack_cnt = 0;
      held    = '0;
      for (int c = 0; c < 9; c++) begin
         d = randData();
         applyStimulus(8'h20, d, !(c >= 3 && c <= 5));
         checkModel("backpressure");
         if (c == 2) held = d[W*5 +: W];
         if (c >= 3 && c <= 5) begin
            checkOutput($sformatf("bp_stall%0d", c), 8'h00, 8'h20, 3'd5, 1'b1, 1'b1, held);
         end
         if (bus.Ack[5]) ack_cnt++;
         if (c == 8) checkInt("bp_released_after_burst", int'(bus.Grant), 0);
         stepEdge();
      end
      checkInt("bp_total_beats", ack_cnt, MAX_BURST);

      doReset();
      ack_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         case (c)
            0, 1, 2: rnd_req = 8'h48;
            3:       rnd_req = 8'h40;
            default: rnd_req = 8'h41;
         endcase
         applyStimulus(rnd_req, randData(), 1'b1);
         checkModel("early_drop");
         if (bus.Ack[3]) ack_cnt++;
         if (c == 5) begin
            checkInt("drop_next_grant", int'(bus.Grant), 8'h40);
            checkInt("drop_next_sel", int'(bus.Sel), 6);
         end
         stepEdge();
      end
      checkInt("drop_beats_from_3", ack_cnt, 2);

      doReset();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(8'h10, randData(), 1'b1);
         checkModel("pre_async_reset");
         if (c < 2) stepEdge();
      end
      checkInt("async_pre_valid", int'(bus.OutValid), 1);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_mid_burst", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, '0);
      modelReset();
      stepEdge();
      rst = 1'b0;
      applyStimulus(8'h81, randData(), 1'b1);
      checkModel("after_async_reset");
      stepEdge();
      applyStimulus(8'h81, randData(), 1'b1);
      checkOutput("restart_at_zero", 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, '0);
      stepEdge();

      rnd_req = 8'h00;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            rnd_req = 8'($urandom) & 8'($urandom);
         end
         rst = ($urandom_range(0, 199) == 0);
         applyStimulus(rnd_req, randData(), $urandom_range(0, 3) != 0);
         if (rst) modelReset();
         checkModel("random");
         stepEdge();
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
